// File: rtl/semafor_pkg.sv
// rtl/semafor_pkg.sv - shared FSM encoding and default timing constants for the train detector
`timescale 1ns/1ps
package semafor_pkg;

    localparam int DEB_LEN_DEF    = 4;
    localparam int STROBE_LEN_DEF = 4;
    localparam int TIMEOUT_DEF    = 1000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTER_A = 3'd1;
    localparam logic [2:0] ST_ENTER_B = 3'd2;
    localparam logic [2:0] ST_CLEAR   = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchroniser plus level debouncer with a one-clock rise event
`timescale 1ns/1ps
module sensor_debounce
    import semafor_pkg::*;
#(
    parameter int DEB_LEN = DEB_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sens,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEB_LEN + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DEB_LEN - 1));

    // The level flips on the DEB_LEN-th consecutive differing sample; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_sens;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 != r_level) begin
                if (w_last) begin
                    r_level <= r_s2;
                    r_rise  <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/train_detector.sv
// rtl/train_detector.sv - two-sensor track section detector with direction, train strobe and sticky fault
`timescale 1ns/1ps
module train_detector
    import semafor_pkg::*;
#(
    parameter int DEB_LEN    = DEB_LEN_DEF,
    parameter int STROBE_LEN = STROBE_LEN_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sens_a,
    input  logic sens_b,
    output logic train,
    output logic occupied,
    output logic dir,
    output logic fault
);

    localparam int DW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STROBE_LEN + 1);

    logic          w_lvl_a, w_rise_a, w_lvl_b, w_rise_b;
    logic [2:0]    r_state, w_state_nx;
    logic [DW-1:0] r_dwell, w_dwell_inc;
    logic [SW-1:0] r_strobe;
    logic          r_dir, w_dir_nx, w_start, w_stay_enter;

    sensor_debounce #(.DEB_LEN(DEB_LEN)) u_deb_a (
        .clk(clk), .rst_n(rst_n), .i_sens(sens_a), .o_level(w_lvl_a), .o_rise(w_rise_a)
    );

    sensor_debounce #(.DEB_LEN(DEB_LEN)) u_deb_b (
        .clk(clk), .rst_n(rst_n), .i_sens(sens_b), .o_level(w_lvl_b), .o_rise(w_rise_b)
    );

    always_comb begin
        w_dwell_inc = (r_dwell == DW'(TIMEOUT)) ? r_dwell : r_dwell + DW'(1);
        w_state_nx  = r_state;
        w_dir_nx    = r_dir;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise_a && w_rise_b) begin
                    w_state_nx = ST_FAULT;
                    w_start    = 1'b1;
                end else if (w_rise_a) begin
                    w_state_nx = ST_ENTER_A;
                    w_dir_nx   = 1'b0;
                    w_start    = 1'b1;
                end else if (w_rise_b) begin
                    w_state_nx = ST_ENTER_B;
                    w_dir_nx   = 1'b1;
                    w_start    = 1'b1;
                end
            end
            // The exit event is tested first so it beats a timeout landing on the same cycle.
            ST_ENTER_A: begin
                if (w_rise_b)                         w_state_nx = ST_CLEAR;
                else if (w_dwell_inc >= DW'(TIMEOUT)) w_state_nx = ST_FAULT;
            end
            ST_ENTER_B: begin
                if (w_rise_a)                         w_state_nx = ST_CLEAR;
                else if (w_dwell_inc >= DW'(TIMEOUT)) w_state_nx = ST_FAULT;
            end
            ST_CLEAR: begin
                if (!w_lvl_a && !w_lvl_b) w_state_nx = ST_IDLE;
            end
            ST_FAULT: w_state_nx = ST_FAULT;
            default:  w_state_nx = ST_IDLE;
        endcase
        w_stay_enter = (w_state_nx == r_state) &&
                       ((r_state == ST_ENTER_A) || (r_state == ST_ENTER_B));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dir    <= 1'b0;
            r_dwell  <= '0;
            r_strobe <= '0;
        end else begin
            r_state <= w_state_nx;
            r_dir   <= w_dir_nx;
            r_dwell <= w_stay_enter ? w_dwell_inc : '0;
            if (w_start)
                r_strobe <= SW'(STROBE_LEN);
            else if (r_strobe != '0)
                r_strobe <= r_strobe - SW'(1);
        end
    end

    assign train    = (r_strobe != '0);
    assign occupied = (r_state != ST_IDLE);
    assign dir      = r_dir;
    assign fault    = (r_state == ST_FAULT);

endmodule

// File: tb/tb_train_detector.sv
// tb/tb_train_detector.sv - directed scoreboard bench for train_detector
`timescale 1ns/1ps
module tb_train_detector;
    import semafor_pkg::*;

    localparam int STROBE = 4;

    typedef struct packed {
        logic chk_dir;
        logic dir;
        logic fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sens_a;
    logic sens_b;
    logic train, occupied, dir, fault;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   mon_w = 0;
    logic mon_prev = 1'b0;
    exp_t e;
    int   k;

    train_detector #(.DEB_LEN(4), .STROBE_LEN(4), .TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n), .sens_a(sens_a), .sens_b(sens_b),
        .train(train), .occupied(occupied), .dir(dir), .fault(fault)
    );

    always #10 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_outs(input string tag, input logic t, input logic o, input logic d, input logic f);
        chk1({tag, "_train"}, train, t);
        chk1({tag, "_occupied"}, occupied, o);
        chk1({tag, "_dir"}, dir, d);
        chk1({tag, "_fault"}, fault, f);
    endtask

    task automatic wait_train(output int found, input int max_clk);
        found = 0;
        for (int i = 1; i <= max_clk; i++) begin
            @(posedge clk);
            #1;
            if (train) begin
                found = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        sens_a = 1'b0;
        sens_b = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    // Pops the scoreboard on each strobe rise and checks the strobe length on its fall.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = 1'b0;
            mon_w    = 0;
        end else begin
            if (train && !mon_prev) begin
                if (sb.size() == 0) begin
                    chk1("unexpected_strobe", train, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk1("strobe_fault", fault, e.fault);
                    if (e.chk_dir) chk1("strobe_dir", dir, e.dir);
                end
                mon_w = 1;
            end else if (train) begin
                mon_w++;
            end else if (mon_prev) begin
                chk_int("strobe_width", mon_w, STROBE);
            end
            mon_prev = train;
        end
    end

    initial begin
        rst_n  = 1'b0;
        sens_a = 1'b0;
        sens_b = 1'b0;
        ticks(3);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_st("reset_state", dut.r_state, ST_IDLE);
        rst_n = 1'b1;
        ticks(2);

        // short glitch on A
        sens_a = 1'b1;
        ticks(3);
        sens_a = 1'b0;
        ticks(15);
        chk_outs("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_st("glitch_state", dut.r_state, ST_IDLE);

        // A then B
        sb.push_back('{chk_dir: 1'b1, dir: 1'b0, fault: 1'b0});
        sens_a = 1'b1;
        wait_train(k, 12);
        chk1("ab_latency", (k >= 1 && k <= 8), 1'b1);
        ticks(20 - k);
        chk_outs("ab_enter", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_st("ab_enter_state", dut.r_state, ST_ENTER_A);
        sens_b = 1'b1;
        ticks(20);
        chk_st("ab_clear_state", dut.r_state, ST_CLEAR);
        sens_a = 1'b0;
        sens_b = 1'b0;
        ticks(2);
        chk1("ab_occ_hold", occupied, 1'b1);
        ticks(10);
        chk_outs("ab_done", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_st("ab_done_state", dut.r_state, ST_IDLE);

        // B then A
        sb.push_back('{chk_dir: 1'b1, dir: 1'b1, fault: 1'b0});
        sens_b = 1'b1;
        ticks(20);
        chk_outs("ba_enter", 1'b0, 1'b1, 1'b1, 1'b0);
        sens_a = 1'b1;
        ticks(20);
        sens_a = 1'b0;
        sens_b = 1'b0;
        ticks(12);
        chk_outs("ba_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_st("ba_done_state", dut.r_state, ST_IDLE);

        // A held alone until timeout
        sb.push_back('{chk_dir: 1'b1, dir: 1'b0, fault: 1'b0});
        sens_a = 1'b1;
        wait_train(k, 12);
        chk1("to_seen", (k != 0), 1'b1);
        repeat (49) @(posedge clk);
        #1;
        chk1("to_before", fault, 1'b0);
        @(posedge clk);
        #1;
        chk1("to_fault", fault, 1'b1);
        chk_st("to_state", dut.r_state, ST_FAULT);
        sens_a = 1'b0;
        ticks(20);
        chk_outs("to_sticky", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_reset();
        ticks(2);
        chk_outs("to_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // simultaneous rise
        sb.push_back('{chk_dir: 1'b0, dir: 1'b0, fault: 1'b1});
        sens_a = 1'b1;
        sens_b = 1'b1;
        wait_train(k, 12);
        chk1("sim_seen", (k != 0), 1'b1);
        chk_st("sim_state", dut.r_state, ST_FAULT);
        ticks(8);
        chk1("sim_fault", fault, 1'b1);
        pulse_reset();
        ticks(2);

        // reset in second clock of strobe
        sb.push_back('{chk_dir: 1'b1, dir: 1'b1, fault: 1'b0});
        sens_b = 1'b1;
        wait_train(k, 12);
        chk1("rs_seen", (k != 0), 1'b1);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        sens_b = 1'b0;
        #1;
        chk_outs("rs_async", 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        rst_n = 1'b1;
        ticks(15);
        chk_outs("rs_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_st("rs_state", dut.r_state, ST_IDLE);

        // sensor already high at reset release
        rst_n  = 1'b0;
        sens_a = 1'b1;
        ticks(2);
        sb.push_back('{chk_dir: 1'b1, dir: 1'b0, fault: 1'b0});
        rst_n = 1'b1;
        wait_train(k, 12);
        chk1("rel_seen", (k >= 1 && k <= 8), 1'b1);
        ticks(8);
        chk_st("rel_state", dut.r_state, ST_ENTER_A);
        pulse_reset();
        ticks(4);

        chk_int("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
